uart_rx: RTL and testbench

Serial receiver stage ahead of the operand/opcode interface FSM. It oversamples the asynchronous `rx` line at 16× the baud rate and recovers 8N1 frames, LSB first. For each good frame it presents the byte on `d_out` with a one-cycle `rx_done` strobe. The interface consumes `d_out`/`rx_done` directly to collect A, the ASCII opcode and B.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx_baud_tick_gen.sv | 26 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio and baud divisor helper.
// Latency: none (package only); backpressure: not applicable.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;

    localparam int OVS = 16;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVS);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, recovered byte plus completion/error strobes out.
// Latency: wires only; backpressure: none, the consumer must keep up with the line rate.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic [DBIT-1:0] d_out;
    logic            rx_done;
    logic            frame_err;
    logic            busy;

    modport master (
        input  rx,
        output d_out,
        output rx_done,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  d_out,
        input  rx_done,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// Free-running divider producing a one-clk tick every DIV clocks (16x oversample rate).
// Latency: tick is decoded from the counter register; backpressure: none.
module baud_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled; byte on d_out with one-clk rx_done, or one-clk frame_err.
// Optional even parity via UART_RX_PARITY_EN; no backpressure, strobes fire once per frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 19200,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int SW  = $clog2((SB_TICK > OVS) ? SB_TICK : OVS);
    localparam int NW  = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            tick;
    logic            rx_meta;
    logic            rx_s;
    state_t          state;
    logic [SW-1:0]   s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] b_reg;
    logic [DBIT-1:0] d_out;
    logic            rx_done;
    logic            frame_err;
    logic            stop_ok;
`ifdef UART_RX_PARITY_EN
    logic            par_err;
`endif

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign stop_ok = rx_s && !par_err;
`else
    assign stop_ok = rx_s;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            b_reg     <= '0;
            d_out     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt == SW'(7)) begin
                            // A start bit that is high again at its centre was only a glitch.
                            if (!rx_s) begin
                                s_cnt <= '0;
                                n_cnt <= '0;
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_cnt == SW'(OVS - 1)) begin
                            s_cnt <= '0;
                            b_reg <= {rx_s, b_reg[DBIT-1:1]};
                            if (n_cnt == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n_cnt <= n_cnt + 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (s_cnt == SW'(OVS - 1)) begin
                            s_cnt   <= '0;
                            par_err <= ^{b_reg, rx_s};
                            state   <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (s_cnt == SW'(SB_TICK - 1)) begin
                            if (stop_ok) begin
                                d_out   <= b_reg;
                                rx_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.d_out     = d_out;
    assign bus.rx_done   = rx_done;
    assign bus.frame_err = frame_err;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 1.6 MHz / 10 kbaud (DIV=10, 160 clk per bit).
module tb_uart_rx;
    localparam int BIT_CLK = 160;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb[$];
    logic [7:0] last_good;

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(
        .CLK_FREQ (1_600_000),
        .BAUD     (10_000),
        .DBIT     (8),
        .SB_TICK  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe from the DUT must match the oldest expected event.
    always @(negedge clk) begin
        if (reset && (bus.rx_done || bus.frame_err)) begin
            chk("strobe_exclusive", int'(bus.rx_done & bus.frame_err), 0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_kind_is_err", int'(bus.frame_err), int'(e.is_err));
                if (!e.is_err) chk("d_out_on_done", int'(bus.d_out), int'(e.data));
            end
        end
    end

    task automatic drive_bit(input logic b, input int len);
        bus.rx = b;
        repeat (len) @(negedge clk);
    endtask

    task automatic expect_evt(input logic is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        sb.push_back(e);
    endtask

    // rst_bit >= 0 pulses reset for 3 clk in the middle of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              input int stop_len, input int rst_bit);
        logic [7:0] v;
        v = d;
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                bus.rx = v[i];
                repeat (80) @(negedge clk);
                reset = 1'b0;
                #1;
                chk("rst_d_out", int'(bus.d_out), 0);
                chk("rst_rx_done", int'(bus.rx_done), 0);
                chk("rst_frame_err", int'(bus.frame_err), 0);
                chk("rst_busy", int'(bus.busy), 0);
                repeat (3) @(negedge clk);
                reset = 1'b1;
                repeat (BIT_CLK - 83) @(negedge clk);
            end else begin
                drive_bit(v[i], BIT_CLK);
            end
        end
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b, BIT_CLK);
`else
        if (par_b === 1'bx) bus.rx = 1'b1;
`endif
        drive_bit(stop_b, stop_len);
        bus.rx = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_good = 8'h00;
        bus.rx    = 1'b1;
        reset     = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_d_out", int'(bus.d_out), 0);
        chk("reset_rx_done", int'(bus.rx_done), 0);
        chk("reset_frame_err", int'(bus.frame_err), 0);
        chk("reset_busy", int'(bus.busy), 0);
        reset = 1'b1;
        repeat (50) @(negedge clk);

        // Single clean frame
        expect_evt(1'b0, 8'h35);
        send_frame(8'h35, 1'b1, ^8'h35, BIT_CLK, -1);
        last_good = 8'h35;
        repeat (200) @(negedge clk);
        chk("d_out_after_35", int'(bus.d_out), 'h35);

        // Back-to-back frames, no idle gap
        expect_evt(1'b0, 8'h2B);
        expect_evt(1'b0, 8'h07);
        send_frame(8'h2B, 1'b1, ^8'h2B, BIT_CLK, -1);
        send_frame(8'h07, 1'b1, ^8'h07, BIT_CLK, -1);
        last_good = 8'h07;
        repeat (200) @(negedge clk);
        chk("d_out_after_b2b", int'(bus.d_out), 'h07);

        // 40-clk glitch on idle line
        drive_bit(1'b0, 40);
        bus.rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_busy", int'(bus.busy), 0);
        chk("glitch_d_out", int'(bus.d_out), int'(last_good));
        chk("glitch_no_pending", sb.size(), 0);

        // Stop bit low; line released well before a re-detected start reaches its centre
        expect_evt(1'b1, 8'h00);
        send_frame(8'hA5, 1'b0, ^8'hA5, 100, -1);
        repeat (400) @(negedge clk);
        chk("ferr_d_out_kept", int'(bus.d_out), int'(last_good));
        chk("ferr_busy", int'(bus.busy), 0);

        // Reset during data bit 4; bits 4..7 (and parity) are high so nothing follows
        send_frame(8'hF0, 1'b1, 1'b1, BIT_CLK, 4);
        last_good = 8'h00;
        repeat (300) @(negedge clk);
        chk("post_rst_busy", int'(bus.busy), 0);
        expect_evt(1'b0, 8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A, BIT_CLK, -1);
        last_good = 8'h5A;
        repeat (200) @(negedge clk);
        chk("d_out_after_5a", int'(bus.d_out), 'h5A);

`ifdef UART_RX_PARITY_EN
        expect_evt(1'b1, 8'h00);
        send_frame(8'h0F, 1'b1, 1'b1, BIT_CLK, -1);
        repeat (200) @(negedge clk);
        chk("par_bad_d_out_kept", int'(bus.d_out), 'h5A);
        expect_evt(1'b0, 8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0, BIT_CLK, -1);
        repeat (200) @(negedge clk);
        chk("par_good_d_out", int'(bus.d_out), 'h0F);
`endif

        repeat (400) @(negedge clk);
        chk("all_events_seen", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
